// File: rtl/crossfade_pkg.sv
// Shared types and default widths for the crossfade sequencer.
// Build option: CROSSFADE_RETRIGGER_EN lets start restart a fade that is in progress.
package crossfade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } crossfade_state_e;

  localparam int DEFAULT_DATA_BITS       = 16;
  localparam int DEFAULT_RATIO_FRAC_BITS = 8;
  localparam int DEFAULT_ACC_BITS        = 24;

endpackage

// File: rtl/lerp.sv
// Combinational linear interpolator: out = (ina*r + inb*(2^F - r)) >> F, truncated.
// Ratio 0 returns inb exactly; the largest ratio reaches (2^F-1)/2^F of the way to ina.
module lerp #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8
) (
  input  logic [INPUT_BITS-1:0]      ina_i,
  input  logic [INPUT_BITS-1:0]      inb_i,
  input  logic [RATIO_FRAC_BITS-1:0] ratio_i,
  output logic [INPUT_BITS-1:0]      out_o
);

  // Sum of both weighted terms never exceeds (2^INPUT_BITS-1)*2^RATIO_FRAC_BITS.
  localparam int PW = INPUT_BITS + RATIO_FRAC_BITS;

  logic [RATIO_FRAC_BITS:0] inv_ratio;
  logic [PW-1:0]            wa;
  logic [PW-1:0]            wb;
  logic [PW-1:0]            mix;

  assign inv_ratio = {1'b1, {RATIO_FRAC_BITS{1'b0}}} - {1'b0, ratio_i};
  assign wa        = PW'(ina_i) * PW'(ratio_i);
  assign wb        = PW'(inb_i) * PW'(inv_ratio);
  assign mix       = wa + wb;
  assign out_o     = INPUT_BITS'(mix >> RATIO_FRAC_BITS);

endmodule

// File: rtl/crossfade_ctrl.sv
// Per-sample crossfade sequencer driving a lerp from src_in to dst_in; one-clock output latency.
// Build option: CROSSFADE_RETRIGGER_EN makes start during RAMP restart the fade.
module crossfade_ctrl
  import crossfade_pkg::*;
#(
  parameter int DATA_BITS       = DEFAULT_DATA_BITS,
  parameter int RATIO_FRAC_BITS = DEFAULT_RATIO_FRAC_BITS,
  parameter int ACC_BITS        = DEFAULT_ACC_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ACC_BITS-1:0]  step,
  input  logic [DATA_BITS-1:0] src_in,
  input  logic [DATA_BITS-1:0] dst_in,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  crossfade_state_e     state_q, state_d;
  logic [ACC_BITS-1:0]  acc_q, acc_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 done_q, done_d;
  logic [ACC_BITS:0]    sum;
  logic [DATA_BITS-1:0] lerp_out;

  lerp #(
    .INPUT_BITS      (DATA_BITS),
    .RATIO_FRAC_BITS (RATIO_FRAC_BITS)
  ) u_lerp (
    .ina_i   (dst_in),
    .inb_i   (src_in),
    .ratio_i (acc_q[ACC_BITS-1 -: RATIO_FRAC_BITS]),
    .out_o   (lerp_out)
  );

  assign sum = {1'b0, acc_q} + {1'b0, step};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;

    // The tick's sample always reflects the state and acc held before this edge.
    if (sample_tick) begin
      case (state_q)
        RAMP:    out_d = lerp_out;
        HOLD:    out_d = dst_in;
        default: out_d = src_in;
      endcase
    end

    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
    end else if (start && state_q != RAMP) begin
      state_d = RAMP;
      acc_d   = '0;
`ifdef CROSSFADE_RETRIGGER_EN
    end else if (start) begin
      acc_d   = '0;
`endif
    end else if (sample_tick && state_q == RAMP) begin
      if (sum[ACC_BITS]) begin
        state_d = HOLD;
        acc_d   = '0;
        done_d  = 1'b1;
      end else begin
        acc_d   = sum[ACC_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= sample_tick;
      busy_q      <= (state_d == RAMP);
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_crossfade_ctrl.sv
// Directed bench for crossfade_ctrl with 8-bit accumulator, 16-bit data.
module tb_crossfade_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        start;
  logic        abort;
  logic [7:0]  step;
  logic [15:0] src_in;
  logic [15:0] dst_in;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  crossfade_ctrl #(
    .DATA_BITS       (16),
    .RATIO_FRAC_BITS (8),
    .ACC_BITS        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .start       (start),
    .abort       (abort),
    .step        (step),
    .src_in      (src_in),
    .dst_in      (dst_in),
    .out         (out),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        abort;
    logic        tick;
    logic [7:0]  step;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] e_out;
    logic        e_vld;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vt[26];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_out, input logic e_vld,
                         input logic e_busy, input logic e_done);
    chk({tag, ".out"},       out,               e_out);
    chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, e_vld});
    chk({tag, ".busy"},      {15'd0, busy},      {15'd0, e_busy});
    chk({tag, ".done"},      {15'd0, done},      {15'd0, e_done});
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic cyc(input logic s, input logic a, input logic t);
    start = s; abort = a; sample_tick = t;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; sample_tick = 1'b0;
  endtask

  initial begin
    // start abort tick step src dst | out vld busy done
    vt[0]  = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0};
    vt[1]  = '{0, 0, 0, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 0};
    vt[2]  = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0};
    vt[3]  = '{1, 0, 0, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 0, 1, 0};
    vt[4]  = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 0};
    vt[5]  = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h3FFF, 1, 1, 0};
    vt[6]  = '{0, 0, 0, 8'h40, 16'h0000, 16'hFFFF, 16'h3FFF, 0, 1, 0};
    vt[7]  = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h7FFF, 1, 1, 0};
    vt[8]  = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'hBFFF, 1, 0, 1};
    vt[9]  = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 0, 0};
    vt[10] = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 0, 0};
    vt[11] = '{1, 0, 0, 8'h80, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 1, 0};
    vt[12] = '{0, 0, 1, 8'h80, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 1, 0};
    vt[13] = '{0, 0, 1, 8'h80, 16'hFFFF, 16'h0000, 16'h7FFF, 1, 0, 1};
    vt[14] = '{0, 0, 1, 8'h80, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0};
    vt[15] = '{0, 0, 1, 8'h80, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0};
    vt[16] = '{1, 0, 0, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 0, 1, 0};
    vt[17] = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 0};
    vt[18] = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h3FFF, 1, 1, 0};
    vt[19] = '{1, 1, 0, 8'h40, 16'h0000, 16'hFFFF, 16'h3FFF, 0, 0, 0};
    vt[20] = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0};
    vt[21] = '{0, 0, 1, 8'h40, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0};
    vt[22] = '{1, 0, 0, 8'h00, 16'h0000, 16'hFFFF, 16'h0000, 0, 1, 0};
    vt[23] = '{0, 0, 1, 8'h00, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 0};
    vt[24] = '{0, 0, 1, 8'h00, 16'h0000, 16'hFFFF, 16'h0000, 1, 1, 0};
    vt[25] = '{0, 1, 0, 8'h00, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 0};

    reset = 1'b1; sample_tick = 1'b0; start = 1'b0; abort = 1'b0;
    step = 8'h40; src_in = 16'h0000; dst_in = 16'hFFFF;
    #12;
    chk_all("reset", 16'h0000, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      step   = vt[i].step;
      src_in = vt[i].src;
      dst_in = vt[i].dst;
      cyc(vt[i].start, vt[i].abort, vt[i].tick);
      chk_all($sformatf("vec%0d", i), vt[i].e_out, vt[i].e_vld, vt[i].e_busy, vt[i].e_done);
    end

    // Start during RAMP once acc has reached 0x80.
    step = 8'h40; src_in = 16'h0000; dst_in = 16'hFFFF;
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk_all("rt.pre", 16'h3FFF, 1, 1, 0);
    cyc(1, 0, 0);
    chk_all("rt.start", 16'h3FFF, 0, 1, 0);
`ifdef CROSSFADE_RETRIGGER_EN
    cyc(0, 0, 1); chk_all("rt.t0", 16'h0000, 1, 1, 0);
    cyc(0, 0, 1); chk_all("rt.t1", 16'h3FFF, 1, 1, 0);
    cyc(0, 0, 1); chk_all("rt.t2", 16'h7FFF, 1, 1, 0);
    cyc(0, 0, 1); chk_all("rt.t3", 16'hBFFF, 1, 0, 1);
`else
    cyc(0, 0, 1); chk_all("rt.t0", 16'h7FFF, 1, 1, 0);
    cyc(0, 0, 1); chk_all("rt.t1", 16'hBFFF, 1, 0, 1);
`endif
    cyc(0, 0, 1); chk_all("rt.hold", 16'hFFFF, 1, 0, 0);
    cyc(0, 1, 0); chk_all("rt.abort", 16'hFFFF, 0, 0, 0);

    // Start with a same-cycle tick from IDLE: that tick is an IDLE sample, next uses ratio 0.
    src_in = 16'h1111;
    cyc(1, 0, 1); chk_all("st.idle", 16'h1111, 1, 1, 0);
    cyc(0, 0, 1); chk_all("st.r0",   16'h1111, 1, 1, 0);
    cyc(0, 0, 1); chk_all("st.r40",  16'h4CCC, 1, 1, 0);

    // Async reset mid-cycle while in RAMP with out_valid high.
    #3;
    reset = 1'b1;
    #1;
    chk_all("arst", 16'h0000, 0, 0, 0);
    #2;
    reset = 1'b0;
    src_in = 16'h5555;
    @(posedge clk);
    #1;
    cyc(0, 0, 1); chk_all("arst.idle", 16'h5555, 1, 0, 0);
    cyc(0, 0, 0); chk_all("arst.quiet", 16'h5555, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crossfade_ctrl.md
Name: crossfade_ctrl

Overview:
- Sample-rate sequencer that drives one `lerp` instance to crossfade from a source signal to a destination signal.
- Steps the lerp ratio once per audio sample tick, using a programmable increment held in a wide accumulator.
- Bypasses the lerp at the end of the fade so the destination value is reached exactly, since the lerp ratio tops out at 255/256.
- Sits between the voice/mixer control logic and the audio datapath.

Parameters:
- DATA_BITS, 16, width of src_in/dst_in/out; passed to lerp INPUT_BITS.
- RATIO_FRAC_BITS, 8, lerp ratio width; ratio = acc[ACC_BITS-1 -: RATIO_FRAC_BITS].
- ACC_BITS, 24, ratio accumulator width; must be >= RATIO_FRAC_BITS.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sample_tick  input  1  one-cycle strobe per audio sample.
- start  input  1  begin a fade; level-sampled each clk.
- abort  input  1  cancel a fade and return to IDLE.
- step  input  ACC_BITS  accumulator increment per tick; sampled on every tick.
- src_in  input  DATA_BITS  signal faded out.
- dst_in  input  DATA_BITS  signal faded in.
- out  output  DATA_BITS  registered mixed sample.
- out_valid  output  1  one-cycle pulse, the cycle after each sample_tick.
- busy  output  1  high while in RAMP.
- done  output  1  one-cycle pulse when the fade completes; coincident with that tick's out_valid.

Behaviour:
- Reset values: out=0, out_valid=0, busy=0, done=0, acc=0, state=IDLE.
- Lerp wiring: ina=dst_in, inb=src_in, ratio=acc top bits. Ratio 0 therefore selects src_in.
- States:
  - IDLE: each tick, out<=src_in.
  - RAMP: each tick, out<=lerp result computed with the pre-increment acc. Then sum = {1'b0,acc}+step:
    - if sum carries out of ACC_BITS: acc<=0, state->HOLD, done pulses.
    - otherwise acc<=sum.
  - HOLD: each tick, out<=dst_in.
- Transitions:
  - IDLE or HOLD with start=1 -> RAMP, acc<=0. busy rises the next cycle.
  - start during RAMP is ignored (see Optional Feature).
  - abort in any state -> IDLE, acc<=0, no done pulse. abort beats start when both are high in the same cycle.
  - start and sample_tick in the same cycle from IDLE: the tick is processed as IDLE (out<=src_in); RAMP begins with acc=0. The first RAMP sample therefore uses ratio 0. From HOLD, the same-cycle tick outputs dst_in.
- Latency: out and out_valid are valid exactly 1 clk after sample_tick. The lerp path is combinational inside that single register stage.
- Fade length: ceil(2^ACC_BITS/step) ticks in RAMP.
  - step=0 is legal: stays in RAMP at ratio 0 indefinitely, busy=1.
  - The final RAMP tick's sample uses the last pre-wrap ratio; the following tick outputs dst_in exactly.
- Ticks closer than 1 clk apart are not supported. Back-to-back ticks on consecutive cycles are supported.
- reset mid-RAMP: immediate return to reset values, no done pulse.

Optional Feature:
- Macro CROSSFADE_RETRIGGER_EN.
- Defined: start in RAMP restarts the fade (acc<=0, stays in RAMP, busy stays 1, no done pulse). abort still has priority over start.
- Undefined: start in RAMP is ignored.

Decomposition:
- Package crossfade_pkg holds:
  - state enum crossfade_state_e {IDLE, RAMP, HOLD};
  - default width localparams.
- Sub-module: instantiate the existing `lerp` (INPUT_BITS=DATA_BITS, RATIO_FRAC_BITS). No other sub-module; the accumulator and FSM are inline.

Test Plan:
All scenarios use ACC_BITS=8, RATIO_FRAC_BITS=8, DATA_BITS=16, src=0x0000, dst=0xFFFF.
- Reset, then ticks in IDLE -> out=0x0000 on each out_valid; busy=0, done=0.
- Fade: start then ticks with step=0x40 -> out 0x0000, 0x3FFF, 0x7FFF, 0xBFFF; done pulses with the 4th out_valid; busy falls; next tick out=0xFFFF and stays 0xFFFF.
- Fade with step=0x80 and src=0xFFFF, dst=0x0000 -> out 0xFFFF, 0x7FFF, then 0x0000 in HOLD.
- abort after 2 RAMP ticks (step=0x40), with start also high in the same cycle -> IDLE; next out=src; no done pulse; busy=0.
- start during RAMP at acc=0x80 -> without CROSSFADE_RETRIGGER_EN, fade continues to 0xC0 then HOLD; with it, acc restarts at 0x00 and out=0x0000 on the next tick.
- Async reset asserted mid-RAMP between clock edges -> out, busy, done and out_valid clear immediately; after release, ticks output src_in.
